// File: rtl/snake_dir_ctrl_pkg.sv
// Shared definitions for the snake direction controller:
// direction codes, run-state encoding and direction helpers.
package snake_pkg;

  // Direction codes as driven on the dir output
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Width of the queue occupancy count; sized for the deepest legal queue (4)
  localparam int QCOUNT_W = 3;

  // Game run state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Opposite directions differ only in the upper code bit
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Bundle of button, timer and status signals between the game
// and the direction controller. The controller takes the slave view.
interface snake_dir_ctrl_if;
  import snake_pkg::*;

  logic [3:0]          btn_db;
  logic                move_tick;
  logic                game_over;
  logic [1:0]          dir;
  logic                running;
  logic [QCOUNT_W-1:0] q_count;
  logic                turn_pulse;
  logic                reject_pulse;
  logic                drop_pulse;

  modport master (
    output btn_db, move_tick, game_over,
    input  dir, running, q_count, turn_pulse, reject_pulse, drop_pulse
  );

  modport slave (
    input  btn_db, move_tick, game_over,
    output dir, running, q_count, turn_pulse, reject_pulse, drop_pulse
  );

endinterface

// File: rtl/snake_dir_ctrl_dir_queue.sv
// Small circular FIFO of 2-bit direction codes. Push and pop may happen
// in the same cycle; a push while full is accepted only alongside a pop.
module dir_queue
  import snake_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [1:0]          pushData_i,
  output logic [1:0]          head_o,
  output logic [1:0]          tail_o,
  output logic [QCOUNT_W-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam logic [1:0]          LAST = 2'(QDEPTH - 1);
  localparam logic [QCOUNT_W-1:0] CAP  = QCOUNT_W'(QDEPTH);

  logic [1:0]          mem_q [QDEPTH];
  logic [1:0]          rdPtr_q, rdPtr_d;
  logic [1:0]          wrPtr_q, wrPtr_d;
  logic [QCOUNT_W-1:0] count_q, count_d;
  logic                doPush, doPop;

  function automatic logic [1:0] nextPtr(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CAP);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign tail_o  = mem_q[(wrPtr_q == 2'd0) ? LAST : wrPtr_q - 2'd1];

  // Qualify requests and compute next pointers and occupancy
  always_comb begin
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = 2'd0;
      wrPtr_d = 2'd0;
      count_d = '0;
    end else begin
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPush && !doPop) count_d = count_q + 1'b1;
      if (doPop && !doPush) count_d = count_q - 1'b1;
    end
  end

  // Pointer, count and storage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q <= 2'd0;
      wrPtr_q <= 2'd0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= 2'd0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (doPush && !flush_i) mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction controller: edge-detects buttons, picks one press per cycle,
// queues turn requests, applies one per move tick, and tracks run state.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] DIR_INIT = 2'd1
) (
  input  logic              clk,
  input  logic              reset,
  snake_dir_ctrl_if.slave   bus
);

  state_e              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [3:0]          btnPrev_q;
  logic                turn_q, turn_d;
  logic                reject_q, reject_d;
  logic                drop_q, drop_d;

  logic [3:0]          rise;
  logic                anyRise;
  logic [1:0]          win;
  logic [3:0]          losers;
  logic                tryEnq;
  logic [1:0]          enqRef;

  logic                qFlush, qPush, qPop;
  logic [1:0]          qHead, qTail;
  logic [QCOUNT_W-1:0] qCount;
  logic                qFull, qEmpty;

  assign rise    = bus.btn_db & ~btnPrev_q;
  assign anyRise = |rise;

  // Lowest-index rising button wins; every other rising bit is a loser
  always_comb begin
    win = 2'd0;
    casez (rise)
      4'b???1: win = 2'd0;
      4'b??10: win = 2'd1;
      4'b?100: win = 2'd2;
      4'b1000: win = 2'd3;
      default: win = 2'd0;
    endcase
    losers = rise & ~(4'b0001 << win);
  end

  dir_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (qFlush),
    .push_i     (qPush),
    .pop_i      (qPop),
    .pushData_i (win),
    .head_o     (qHead),
    .tail_o     (qTail),
    .count_o    (qCount),
    .full_o     (qFull),
    .empty_o    (qEmpty)
  );

  // Run-state transitions, tick-driven turn application and enqueue qualification
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    turn_d   = 1'b0;
    reject_d = 1'b0;
    drop_d   = 1'b0;
    qFlush   = 1'b0;
    qPush    = 1'b0;
    qPop     = 1'b0;
    tryEnq   = 1'b0;
    enqRef   = dir_q;

    if (bus.game_over) begin
      // Collision outranks everything: drop queued turns, freeze direction
      state_d = ST_OVER;
      qFlush  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (anyRise) begin
            state_d = ST_RUN;
            tryEnq  = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.move_tick && !qEmpty) begin
            qPop = 1'b1;
            if (qHead != dir_q && qHead != opposite(dir_q)) begin
              dir_d  = qHead;
              turn_d = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
          tryEnq = anyRise;
        end
        ST_OVER: begin
          // A fresh press restarts to IDLE but is not itself queued
          if (anyRise) begin
            state_d = ST_IDLE;
            dir_d   = DIR_INIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (tryEnq) begin
      // Compare against the direction the snake will have when this entry
      // would otherwise be reached, so repeats are discarded early
      if (qEmpty || (qPop && qCount == QCOUNT_W'(1))) enqRef = dir_q;
      else                                            enqRef = qTail;
      if (win != enqRef) begin
        if (qFull && !qPop) drop_d = 1'b1;
        else                qPush  = 1'b1;
      end
      if (|losers) drop_d = 1'b1;
    end
  end

  // State, direction, button history and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_INIT;
      btnPrev_q <= 4'd0;
      turn_q    <= 1'b0;
      reject_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      btnPrev_q <= bus.btn_db;
      turn_q    <= turn_d;
      reject_q  <= reject_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.dir          = dir_q;
  assign bus.running      = (state_q == ST_RUN);
  assign bus.q_count      = qCount;
  assign bus.turn_pulse   = turn_q;
  assign bus.reject_pulse = reject_q;
  assign bus.drop_pulse   = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: each driven cycle queues the
// hand-computed outputs expected after that clock edge; a monitor checks them.
module tb_snake_dir_ctrl;

  typedef struct {
    string      tag;
    logic [1:0] dir;
    logic       run;
    logic [2:0] cnt;
    logic       turn;
    logic       rej;
    logic       drop;
  } exp_t;

  logic clk;
  logic reset;
  exp_t expQ[$];
  int   numChecks;
  int   numFails;

  snake_dir_ctrl_if bus();

  snake_dir_ctrl #(.QDEPTH(2), .DIR_INIT(2'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] btn,
                               input logic tick, input logic go, input logic [1:0] eDir,
                               input logic eRun, input logic [2:0] eCnt, input logic eTurn,
                               input logic eRej, input logic eDrop);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.btn_db    = btn;
    bus.move_tick = tick;
    bus.game_over = go;
    e.tag = tag; e.dir = eDir; e.run = eRun; e.cnt = eCnt;
    e.turn = eTurn; e.rej = eRej; e.drop = eDrop;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    numChecks++;
    if (bus.dir !== e.dir || bus.running !== e.run || bus.q_count !== e.cnt ||
        bus.turn_pulse !== e.turn || bus.reject_pulse !== e.rej || bus.drop_pulse !== e.drop) begin
      numFails++;
      $display("[TB] FAIL %s: got dir=%0d run=%0d cnt=%0d turn=%0d rej=%0d drop=%0d, expected dir=%0d run=%0d cnt=%0d turn=%0d rej=%0d drop=%0d",
               e.tag, bus.dir, bus.running, bus.q_count, bus.turn_pulse, bus.reject_pulse,
               bus.drop_pulse, e.dir, e.run, e.cnt, e.turn, e.rej, e.drop);
    end
  endtask

  // Monitor: just after every rising edge, compare against the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    numChecks     = 0;
    numFails      = 0;
    reset         = 1'b1;
    bus.btn_db    = 4'd0;
    bus.move_tick = 1'b0;
    bus.game_over = 1'b0;

    //            tag        rst btn   tk go  dir  run cnt   t  r  d
    applyStimulus("rst0",    1, 4'h0, 0, 0, 2'd1, 0, 3'd0, 0, 0, 0);
    applyStimulus("rst1",    1, 4'h0, 0, 0, 2'd1, 0, 3'd0, 0, 0, 0);
    // Press DOWN from IDLE, then a tick turns RIGHT->DOWN
    applyStimulus("t1press", 0, 4'h4, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    applyStimulus("t1tick",  0, 4'h0, 1, 0, 2'd2, 1, 3'd0, 1, 0, 0);
    applyStimulus("t1idle",  0, 4'h0, 0, 0, 2'd2, 1, 3'd0, 0, 0, 0);
    applyStimulus("toRpr",   0, 4'h2, 0, 0, 2'd2, 1, 3'd1, 0, 0, 0);
    applyStimulus("toRtk",   0, 4'h0, 1, 0, 2'd1, 1, 3'd0, 1, 0, 0);
    // Reversal RIGHT->LEFT is rejected at the tick
    applyStimulus("t2press", 0, 4'h8, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    applyStimulus("t2tick",  0, 4'h0, 1, 0, 2'd1, 1, 3'd0, 0, 1, 0);
    // Fill the queue with UP, LEFT; DOWN overflows
    applyStimulus("t3up",    0, 4'h1, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    applyStimulus("t3rel",   0, 4'h0, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    applyStimulus("t3left",  0, 4'h8, 0, 0, 2'd1, 1, 3'd2, 0, 0, 0);
    applyStimulus("t3rel2",  0, 4'h0, 0, 0, 2'd1, 1, 3'd2, 0, 0, 0);
    applyStimulus("t3full",  0, 4'h4, 0, 0, 2'd1, 1, 3'd2, 0, 0, 1);
    applyStimulus("t3tk1",   0, 4'h0, 1, 0, 2'd0, 1, 3'd1, 1, 0, 0);
    applyStimulus("t3tk2",   0, 4'h0, 1, 0, 2'd3, 1, 3'd0, 1, 0, 0);
    // UP and DOWN together: UP wins, DOWN dropped
    applyStimulus("t4both",  0, 4'h5, 0, 0, 2'd3, 1, 3'd1, 0, 0, 1);
    applyStimulus("t4rel",   0, 4'h0, 0, 0, 2'd3, 1, 3'd1, 0, 0, 0);
    // Full queue with simultaneous pop and push
    applyStimulus("t5fill",  0, 4'h2, 0, 0, 2'd3, 1, 3'd2, 0, 0, 0);
    applyStimulus("t5rel",   0, 4'h0, 0, 0, 2'd3, 1, 3'd2, 0, 0, 0);
    applyStimulus("t5both",  0, 4'h4, 1, 0, 2'd0, 1, 3'd2, 1, 0, 0);
    // Game over flushes; restart via press, then another press runs
    applyStimulus("t6over",  0, 4'h0, 0, 1, 2'd0, 0, 3'd0, 0, 0, 0);
    applyStimulus("t6ovtk",  0, 4'h0, 1, 1, 2'd0, 0, 3'd0, 0, 0, 0);
    applyStimulus("t6lowtk", 0, 4'h0, 1, 0, 2'd0, 0, 3'd0, 0, 0, 0);
    applyStimulus("t6rst",   0, 4'h2, 0, 0, 2'd1, 0, 3'd0, 0, 0, 0);
    applyStimulus("t6idtk",  0, 4'h0, 1, 0, 2'd1, 0, 3'd0, 0, 0, 0);
    applyStimulus("t6run",   0, 4'h1, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    applyStimulus("t6rel",   0, 4'h0, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    // Apply queued UP, then a same-direction press is silently discarded
    applyStimulus("sdTick",  0, 4'h0, 1, 0, 2'd0, 1, 3'd0, 1, 0, 0);
    applyStimulus("sdSame",  0, 4'h1, 0, 0, 2'd0, 1, 3'd0, 0, 0, 0);
    applyStimulus("sdRel",   0, 4'h0, 0, 0, 2'd0, 1, 3'd0, 0, 0, 0);
    // Queue DOWN then UP: first pop is a reversal, second equals dir
    applyStimulus("rjDown",  0, 4'h4, 0, 0, 2'd0, 1, 3'd1, 0, 0, 0);
    applyStimulus("rjRel",   0, 4'h0, 0, 0, 2'd0, 1, 3'd1, 0, 0, 0);
    applyStimulus("rjUp",    0, 4'h1, 0, 0, 2'd0, 1, 3'd2, 0, 0, 0);
    applyStimulus("rjTk1",   0, 4'h0, 1, 0, 2'd0, 1, 3'd1, 0, 1, 0);
    applyStimulus("rjTk2",   0, 4'h0, 1, 0, 2'd0, 1, 3'd0, 0, 1, 0);
    // Button held through reset rises right after reset
    applyStimulus("hrRst",   1, 4'h1, 0, 0, 2'd1, 0, 3'd0, 0, 0, 0);
    applyStimulus("hrRise",  0, 4'h1, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);
    applyStimulus("hrHold",  0, 4'h1, 0, 0, 2'd1, 1, 3'd1, 0, 0, 0);

    begin
      int waitCycles;
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 20) begin
        @(posedge clk);
        waitCycles++;
      end
      #2;
      if (expQ.size() > 0) begin
        numChecks++;
        numFails++;
        $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
